// File: rtl/mips_dmem_responder.sv
// Data-memory responder for the MIPS MEM stage.
// Big-endian byte/half/word access with a fixed response latency.
module mips_dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] addr,
    input  logic [1:0]  memwrite,
    input  logic [1:0]  loadsize,
    input  logic        loadsigned,
    input  logic [31:0] writedata,
    output logic        rsp_valid,
    output logic [31:0] readdata,
    output logic        misalign,
    output logic        stall
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [AW+1:0] r_addr;
    logic [1:0]    r_memwrite;
    logic [1:0]    r_loadsize;
    logic          r_loadsigned;
    logic [31:0]   r_wdata;
    logic          r_ready;
    logic          r_rsp_valid;
    logic          r_stall;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic [AW-1:0] w_idx;
    logic [31:0]   w_word;
    logic          w_is_store;
    logic          w_misal;
    logic [4:0]    w_shift;
    logic [3:0]    w_be;
    logic [31:0]   w_sdata;
    logic [31:0]   w_sh;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load;
    logic          w_unused;

    assign w_unused = ^addr[31:AW+2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_memwrite   <= '0;
            r_loadsize   <= '0;
            r_loadsigned <= 1'b0;
            r_wdata      <= '0;
            r_ready      <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_stall      <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_addr       <= addr[AW+1:0];
                        r_memwrite   <= memwrite;
                        r_loadsize   <= loadsize;
                        r_loadsigned <= loadsigned;
                        r_wdata      <= writedata;
                        r_cnt        <= CNT_INIT;
                        r_ready      <= 1'b0;
                        r_stall      <= 1'b1;
                        if (LATENCY == 1) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                    end
                end
                S_RESP: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_ready     <= 1'b1;
                    r_stall     <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_idx      = r_addr[AW+1:2];
    assign w_word     = r_mem[w_idx];
    assign w_is_store = (r_memwrite != 2'b00);
    // Lane 0 is the most significant byte, so shift by (3 - lane) bytes.
    assign w_shift    = {~r_addr[1:0], 3'b000};

    always_comb begin
        w_misal = 1'b0;
        if (w_is_store) begin
            unique case (r_memwrite)
                2'b10:   w_misal = r_addr[0];
                2'b11:   w_misal = (r_addr[1:0] != 2'b00);
                default: w_misal = 1'b0;
            endcase
        end else begin
            unique case (r_loadsize)
                2'b01:   w_misal = 1'b0;
                2'b10:   w_misal = r_addr[0];
                default: w_misal = (r_addr[1:0] != 2'b00);
            endcase
        end
    end

    always_comb begin
        w_be    = 4'b1111;
        w_sdata = r_wdata;
        unique case (r_memwrite)
            2'b01: begin
                w_be    = 4'b1000 >> r_addr[1:0];
                w_sdata = {24'b0, r_wdata[7:0]} << w_shift;
            end
            2'b10: begin
                w_be    = r_addr[1] ? 4'b0011 : 4'b1100;
                w_sdata = r_addr[1] ? {16'b0, r_wdata[15:0]}
                                    : {r_wdata[15:0], 16'b0};
            end
            default: begin
                w_be    = 4'b1111;
                w_sdata = r_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (r_state == S_RESP && w_is_store && !w_misal) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_sdata[b*8 +: 8];
            end
        end
    end

    assign w_sh   = w_word >> w_shift;
    assign w_byte = w_sh[7:0];
    assign w_half = r_addr[1] ? w_word[15:0] : w_word[31:16];

    always_comb begin
        w_load = w_word;
        unique case (r_loadsize)
            2'b01:   w_load = {{24{r_loadsigned & w_byte[7]}}, w_byte};
            2'b10:   w_load = {{16{r_loadsigned & w_half[15]}}, w_half};
            default: w_load = w_word;
        endcase
    end

    assign req_ready = r_ready;
    assign rsp_valid = r_rsp_valid;
    assign stall     = r_stall;
    assign misalign  = r_rsp_valid & w_misal;
    assign readdata  = (r_rsp_valid && !w_is_store && !w_misal) ? w_load : 32'h0;

endmodule

// File: doc/mips_dmem_responder.md
Name: mips_dmem_responder

Overview:
- Data-memory responder at the far end of the pipelined MIPS MEM-stage load/store interface.
- Accepts one request at a time from the core and returns the response after a fixed, parameterised latency.
- Stores use the 2-bit memwrite size code: byte, half or word, with byte-lane merge.
- Loads support lb/lbu/lh/lhu/lw, with sign or zero extension. Memory is big-endian.

Parameters:
DEPTH_WORDS, 64, number of 32-bit words; power of 2, at least 4.
LATENCY, 2, cycles from request accept to rsp_valid; at least 1.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low (0 = reset asserted)
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
addr  in  32  byte address
memwrite  in  2  00 = load, 01 = store byte, 10 = store half, 11 = store word
loadsize  in  2  00 = word, 01 = byte, 10 = half, 11 = reserved (treated as word); ignored on stores
loadsigned  in  1  1 = sign-extend byte/half loads
writedata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
rsp_valid  out  1  response valid for exactly one cycle
readdata  out  32  extended load data; 0 for stores and misaligned requests
misalign  out  1  response flag: request was misaligned and was not performed
stall  out  1  high whenever state is not IDLE

Behaviour:
- Reset (reset = 0, asynchronous):
  - State goes to IDLE and the latency counter clears.
  - req_ready = 1, rsp_valid = 0, readdata = 0, misalign = 0, stall = 0.
  - Memory array contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready = 1. When req_valid = 1 at a clock edge, capture addr, memwrite, loadsize, loadsigned and writedata, and load the counter with LATENCY-1.
    - If LATENCY = 1, go directly to RESP.
    - Otherwise go to WAIT.
  - WAIT: req_ready = 0. Decrement the counter each cycle and go to RESP when it reaches 0.
    - A request is therefore accepted at edge N and rsp_valid is high in the cycle following edge N+LATENCY-1. This gives exactly LATENCY cycles of accept-to-response.
  - RESP: rsp_valid = 1 for one cycle with readdata and misalign driven. Return to IDLE on the next edge. req_ready = 0 in RESP, so there is no back-to-back accept.
- Word index: addr[log2(DEPTH_WORDS)+1 : 2]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
- Byte lanes (big-endian):
  - addr[1:0] = 0 selects bits [31:24]; addr[1:0] = 3 selects bits [7:0].
  - Half at addr[1] = 0 selects [31:16]; addr[1] = 1 selects [15:0].
- Alignment:
  - Half access requires addr[0] = 0.
  - Word access requires addr[1:0] = 0.
  - Byte access is always aligned.
  - Misaligned request: no memory update, readdata = 0, misalign = 1 in RESP.
- Store commit: byte-enable merge into the addressed word at the clock edge ending RESP. Only the selected lanes change.
- Load data: sampled from memory in RESP, combinationally from captured state.
  - Byte and half loads: zero-extended when loadsigned = 0; bit 7 or bit 15 replicated when loadsigned = 1.
- Reset during WAIT or RESP aborts the request: a pending store is discarded and no response is issued.
- req_valid outside IDLE is ignored. The core must hold the request until req_ready = 1.

Test Plan:
- Reset low for 2 cycles, then release → req_ready = 1, rsp_valid = 0, stall = 0. Re-assert reset while in WAIT → next cycle state is IDLE and no rsp_valid occurs.
- Store word 0x80FF7F01 to addr 80 → rsp_valid exactly 2 cycles after accept (LATENCY = 2), stall high in the accept+1 and accept+2 cycles. Then:
  - lw @80 returns 0x80FF7F01.
  - lbu @81 returns 0x000000FF.
  - lb @81 returns 0xFFFFFFFF.
  - lb @82 returns 0x0000007F.
- Load halves @80 → lh returns 0xFFFF80FF, lhu returns 0x000080FF. lhu @82 returns 0x00007F01.
- Store byte 0xAA to addr 83, then lw @80 → returns 0x80FF7FAA. Store half 0x1234 to addr 80, then lw @80 → returns 0x12347FAA.
- Misaligned: sw @81 and lh @83 → misalign = 1, readdata = 0, and a following lw @80 is unchanged. Aliasing: sw @(80 + 4*DEPTH_WORDS) with data 0x5 → lw @80 returns 0x00000005.
- Handshake: hold req_valid = 1 continuously → one accept per LATENCY+1 cycles, rsp_valid never high for 2 consecutive cycles. Repeat with LATENCY = 1 → response in the cycle after accept.
